// File: rtl/p_dispatch_if.sv
// Dispatch-stage bundle type and the rename/writeback/issue-queue interface bundle.
// Upstream (rename + queues) drives through master; p_dispatch sits on slave.
package p_dispatch_pkg;
  localparam int unsigned ROB_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NSLOT  = 2;
  localparam int unsigned NSRC   = 4;

  typedef logic [ROB_W-1:0] rob_id_t;

  // Slot s owns operands 2s and 2s+1
  typedef struct packed {
    logic [NSLOT-1:0]              r_valid;
    logic [NSLOT-1:0]              lsu_type;
    logic [NSLOT-1:0]              mdu_type;
    rob_id_t [NSLOT-1:0]           rob_id;
    logic [NSRC-1:0]               data_valid;
    rob_id_t [NSRC-1:0]            src_preg;
    logic [NSRC-1:0][DATA_W-1:0]   arf_data;
  } r_p_pkg_t;
endpackage

interface p_dispatch_if;
  import p_dispatch_pkg::*;

  logic                    c_flush;
  logic                    r_p_valid;
  logic                    r_p_ready;
  r_p_pkg_t                r_p_data;
  logic [1:0]              wb_valid;
  rob_id_t [1:0]           wb_robid;
  logic [1:0][DATA_W-1:0]  wb_data;
  logic [1:0]              alu_free;
  logic [1:0]              mdu_free;
  logic [1:0]              lsu_free;
  logic [1:0]              alu_valid;
  logic [1:0]              mdu_valid;
  logic [1:0]              lsu_valid;
  logic [1:0]              alu_slot;
  logic [1:0]              mdu_slot;
  logic [1:0]              lsu_slot;
  r_p_pkg_t                disp_pkg;

  modport master (
    output c_flush, r_p_valid, r_p_data, wb_valid, wb_robid, wb_data,
           alu_free, mdu_free, lsu_free,
    input  r_p_ready, alu_valid, mdu_valid, lsu_valid,
           alu_slot, mdu_slot, lsu_slot, disp_pkg
  );

  modport slave (
    input  c_flush, r_p_valid, r_p_data, wb_valid, wb_robid, wb_data,
           alu_free, mdu_free, lsu_free,
    output r_p_ready, alu_valid, mdu_valid, lsu_valid,
           alu_slot, mdu_slot, lsu_slot, disp_pkg
  );
endinterface

// File: rtl/p_dispatch.sv
// Dispatch stage: buffers one 2-wide renamed bundle, wakes its operands from writeback,
// and writes its slots in program order into the ALU/MDU/LSU issue queues.
module p_dispatch
  import p_dispatch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  p_dispatch_if.slave  bus
);

  // State encoding is the per-slot pending mask itself
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL0 = 2'b01,
    ST_PART  = 2'b10,
    ST_FULL  = 2'b11
  } pend_e;

  typedef enum logic [1:0] {
    Q_ALU = 2'd0,
    Q_MDU = 2'd1,
    Q_LSU = 2'd2
  } queue_e;

  pend_e      state;
  pend_e      state_nxt;
  r_p_pkg_t   bndl_q;
  r_p_pkg_t   bndl_m;
  r_p_pkg_t   in_m;
  queue_e     tgt0;
  queue_e     tgt1;
  logic       same_q;
  logic [1:0] go;
  logic       ready;
  logic       accept;
  logic [2:0][1:0] qv;
  logic [2:0][1:0] qs;

  // Merge writeback results into not-yet-valid operands; port 0 has priority
  function automatic r_p_pkg_t wakeup(input r_p_pkg_t p, input logic [1:0] v,
                                      input rob_id_t [1:0] id,
                                      input logic [1:0][DATA_W-1:0] d);
    r_p_pkg_t r;
    r = p;
    for (int k = 0; k < int'(NSRC); k++) begin
      if (!p.data_valid[k]) begin
        if (v[0] && (id[0] == p.src_preg[k])) begin
          r.data_valid[k] = 1'b1;
          r.arf_data[k]   = d[0];
        end else if (v[1] && (id[1] == p.src_preg[k])) begin
          r.data_valid[k] = 1'b1;
          r.arf_data[k]   = d[1];
        end
      end
    end
    return r;
  endfunction

  function automatic queue_e route(input logic is_lsu, input logic is_mdu);
    queue_e q;
    if (is_lsu)      q = Q_LSU;
    else if (is_mdu) q = Q_MDU;
    else             q = Q_ALU;
    return q;
  endfunction

  function automatic logic [1:0] free_of(input queue_e q, input logic [1:0] a,
                                         input logic [1:0] m, input logic [1:0] l);
    logic [1:0] f;
    case (q)
      Q_MDU:   f = m;
      Q_LSU:   f = l;
      default: f = a;
    endcase
    return f;
  endfunction

  // Same-cycle wakeup view of the held bundle and of the incoming one
  always_comb begin
    bndl_m       = wakeup(bndl_q, bus.wb_valid, bus.wb_robid, bus.wb_data);
    in_m         = wakeup(bus.r_p_data, bus.wb_valid, bus.wb_robid, bus.wb_data);
    bus.disp_pkg = bndl_m;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next-state, in-order dispatch decision and queue port mapping
  always_comb begin
    state_nxt = state;
    go        = 2'b00;
    qv        = '0;
    qs        = '0;
    ready     = 1'b0;
    accept    = 1'b0;
    tgt0      = route(bndl_q.lsu_type[0], bndl_q.mdu_type[0]);
    tgt1      = route(bndl_q.lsu_type[1], bndl_q.mdu_type[1]);
    same_q    = (tgt0 == tgt1);

    if (!bus.c_flush) begin
      go[0] = state[0] &&
              (free_of(tgt0, bus.alu_free, bus.mdu_free, bus.lsu_free) != 2'd0);
      go[1] = state[1] && (!state[0] || go[0]) &&
              (free_of(tgt1, bus.alu_free, bus.mdu_free, bus.lsu_free) >=
               (2'd1 + 2'(go[0] && same_q)));
    end

    if (go[0]) begin
      qv[tgt0][0] = 1'b1;
      qs[tgt0][0] = 1'b0;
    end
    // Slot1 takes port1 only when slot0 already holds port0 of the same queue
    if (go[1]) begin
      if (go[0] && same_q) begin
        qv[tgt1][1] = 1'b1;
        qs[tgt1][1] = 1'b1;
      end else begin
        qv[tgt1][0] = 1'b1;
        qs[tgt1][0] = 1'b1;
      end
    end

    ready  = !bus.c_flush && ((state & ~go) == 2'b00);
    accept = bus.r_p_valid && ready;

    if (bus.c_flush)  state_nxt = ST_EMPTY;
    else if (accept)  state_nxt = pend_e'(bus.r_p_data.r_valid);
    else              state_nxt = pend_e'(state & ~go);

    bus.r_p_ready = ready;
    bus.alu_valid = qv[Q_ALU];
    bus.mdu_valid = qv[Q_MDU];
    bus.lsu_valid = qv[Q_LSU];
    bus.alu_slot  = qs[Q_ALU];
    bus.mdu_slot  = qs[Q_MDU];
    bus.lsu_slot  = qs[Q_LSU];
  end

  // Held bundle keeps absorbing wakeups; a new bundle is captured already merged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bndl_q <= '0;
    else if (accept) bndl_q <= in_m;
    else             bndl_q <= bndl_m;
  end

endmodule
